// File: rtl/ccl_multi_seq.sv
// Multi-channel CCW command-list sequencer. Each channel holds its own CCW
// context; ready channels are served round-robin on a single memory-cycle port.
module ccl_multi_seq #(
  parameter int NCHAN = 8,
  parameter int WCW   = 11,
  parameter int ADRW  = 22,
  localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk_ccl_h,
  input  logic             crc_reset_l,
  input  logic             ccw_load_h,
  input  logic [CHW-1:0]   ccw_chan_h,
  input  logic [WCW-1:0]   ccw_wc_h,
  input  logic [ADRW-1:0]  ccw_adr_h,
  input  logic             ccw_reverse_h,
  input  logic             ccw_zero_fill_h,
  input  logic             ccw_last_h,
  input  logic [NCHAN-1:0] ch_abort_h,
  input  logic [NCHAN-1:0] ch_intr_clr_h,
  output logic             mem_req_h,
  output logic [CHW-1:0]   mem_chan_h,
  output logic [ADRW-1:0]  mem_adr_h,
  output logic             mem_zero_fill_h,
  input  logic             mem_ack_h,
  input  logic             mem_done_h,
  input  logic             mem_err_h,
  output logic [NCHAN-1:0] ccl_ccwf_req_h,
  output logic [NCHAN-1:0] ccl_act_h,
  output logic [NCHAN-1:0] ccl_done_intr_h,
  output logic [NCHAN-1:0] ccl_mem_err_h,
  output logic [NCHAN-1:0] ccl_ovn_err_h,
  input  logic [CHW-1:0]   stat_chan_h,
  output logic [WCW-1:0]   stat_wc_h,
  output logic [ADRW-1:0]  stat_adr_h
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACTIVE, ST_WAIT, ST_FETCH, ST_DONE, ST_ERROR
  } state_t;

  state_t          state_reg [NCHAN];
  state_t          state_next [NCHAN];
  logic [WCW-1:0]  wc_reg [NCHAN];
  logic [WCW-1:0]  wc_next [NCHAN];
  logic [ADRW-1:0] adr_reg [NCHAN];
  logic [ADRW-1:0] adr_next [NCHAN];

  logic [NCHAN-1:0] rev_reg, rev_next, zf_reg, zf_next, last_reg, last_next;
  logic [NCHAN-1:0] done_reg, done_next, merr_reg, merr_next, ovn_reg, ovn_next;
  logic [NCHAN-1:0] abp_reg, abp_next;

  logic            req_reg, req_next, outst_reg, outst_next;
  logic [CHW-1:0]  chan_reg, chan_next, rr_reg, rr_next;
  logic [ADRW-1:0] madr_reg, madr_next;
  logic            mzf_reg, mzf_next;

  logic            arb_en, done_hit, grant_valid, grant_zf;
  logic [CHW-1:0]  grant_chan;
  logic [ADRW-1:0] grant_adr;

  assign arb_en   = !req_reg && !outst_reg;
  assign done_hit = outst_reg && mem_done_h;

  // Scan downward so the channel closest after the pointer is the last write.
  always_comb begin
    grant_valid = 1'b0;
    grant_chan  = '0;
    grant_adr   = '0;
    grant_zf    = 1'b0;
    for (int k = NCHAN; k >= 1; k--) begin
      int idx;
      idx = (int'(rr_reg) + k) % NCHAN;
      if (state_reg[idx] == ST_ACTIVE && !ch_abort_h[idx]) begin
        grant_valid = 1'b1;
        grant_chan  = CHW'(idx);
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (grant_chan == CHW'(i)) begin
        grant_adr = adr_reg[i];
        grant_zf  = zf_reg[i];
      end
    end
  end

  always_comb begin
    req_next   = req_reg;
    outst_next = outst_reg;
    chan_next  = chan_reg;
    rr_next    = rr_reg;
    madr_next  = madr_reg;
    mzf_next   = mzf_reg;
    if (req_reg && mem_ack_h) begin
      req_next   = 1'b0;
      outst_next = 1'b1;
    end
    if (done_hit) outst_next = 1'b0;
    if (arb_en && grant_valid) begin
      req_next  = 1'b1;
      chan_next = grant_chan;
      rr_next   = grant_chan;
      madr_next = grant_adr;
      mzf_next  = grant_zf;
    end
  end

  always_comb begin
    rev_next  = rev_reg;
    zf_next   = zf_reg;
    last_next = last_reg;
    done_next = done_reg;
    merr_next = merr_reg;
    ovn_next  = ovn_reg;
    abp_next  = abp_reg;
    for (int i = 0; i < NCHAN; i++) begin
      logic sel_load, sel_done, sel_grant;
      logic [WCW-1:0] wc_dec;
      state_next[i] = state_reg[i];
      wc_next[i]    = wc_reg[i];
      adr_next[i]   = adr_reg[i];
      sel_load  = ccw_load_h && (ccw_chan_h == CHW'(i));
      sel_done  = done_hit && (chan_reg == CHW'(i));
      sel_grant = arb_en && grant_valid && (grant_chan == CHW'(i));
      wc_dec    = wc_reg[i] - 1'b1;
      // Clear first so any flag set later in this cycle takes precedence.
      if (ch_intr_clr_h[i]) begin
        done_next[i] = 1'b0;
        merr_next[i] = 1'b0;
        ovn_next[i]  = 1'b0;
      end
      case (state_reg[i])
        ST_IDLE, ST_FETCH, ST_DONE: begin
          if (ch_abort_h[i]) begin
            state_next[i] = ST_IDLE;
          end else if (sel_load) begin
            wc_next[i]   = ccw_wc_h;
            adr_next[i]  = ccw_adr_h;
            rev_next[i]  = ccw_reverse_h;
            zf_next[i]   = ccw_zero_fill_h;
            last_next[i] = ccw_last_h;
            done_next[i] = 1'b0;
            if (ccw_wc_h != '0) begin
              state_next[i] = ST_ACTIVE;
            end else if (ccw_last_h) begin
              state_next[i] = ST_DONE;
              done_next[i]  = 1'b1;
            end else begin
              state_next[i] = ST_FETCH;
            end
          end else if (state_reg[i] == ST_DONE && ch_intr_clr_h[i]) begin
            state_next[i] = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (sel_load) ovn_next[i] = 1'b1;
          if (ch_abort_h[i])  state_next[i] = ST_IDLE;
          else if (sel_grant) state_next[i] = ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_load) ovn_next[i] = 1'b1;
          if (sel_done) begin
            if (abp_reg[i] || ch_abort_h[i]) begin
              state_next[i] = ST_IDLE;
              abp_next[i]   = 1'b0;
            end else if (mem_err_h) begin
              state_next[i] = ST_ERROR;
              merr_next[i]  = 1'b1;
            end else begin
              wc_next[i]  = wc_dec;
              adr_next[i] = rev_reg[i] ? adr_reg[i] - 1'b1 : adr_reg[i] + 1'b1;
              if (wc_dec != '0) begin
                state_next[i] = ST_ACTIVE;
              end else if (last_reg[i]) begin
                state_next[i] = ST_DONE;
                done_next[i]  = 1'b1;
              end else begin
                state_next[i] = ST_FETCH;
              end
            end
          end else if (ch_abort_h[i]) begin
            abp_next[i] = 1'b1;
          end
        end
        ST_ERROR: begin
          if (sel_load) ovn_next[i] = 1'b1;
          if (ch_intr_clr_h[i]) state_next[i] = ST_IDLE;
        end
        default: state_next[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ccl_h or negedge crc_reset_l) begin
    if (!crc_reset_l) begin
      for (int i = 0; i < NCHAN; i++) begin
        state_reg[i] <= ST_IDLE;
        wc_reg[i]    <= '0;
        adr_reg[i]   <= '0;
      end
      rev_reg   <= '0;
      zf_reg    <= '0;
      last_reg  <= '0;
      done_reg  <= '0;
      merr_reg  <= '0;
      ovn_reg   <= '0;
      abp_reg   <= '0;
      req_reg   <= 1'b0;
      outst_reg <= 1'b0;
      chan_reg  <= '0;
      rr_reg    <= CHW'(NCHAN - 1);
      madr_reg  <= '0;
      mzf_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        state_reg[i] <= state_next[i];
        wc_reg[i]    <= wc_next[i];
        adr_reg[i]   <= adr_next[i];
      end
      rev_reg   <= rev_next;
      zf_reg    <= zf_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      merr_reg  <= merr_next;
      ovn_reg   <= ovn_next;
      abp_reg   <= abp_next;
      req_reg   <= req_next;
      outst_reg <= outst_next;
      chan_reg  <= chan_next;
      rr_reg    <= rr_next;
      madr_reg  <= madr_next;
      mzf_reg   <= mzf_next;
    end
  end

  assign mem_req_h       = req_reg;
  assign mem_chan_h      = chan_reg;
  assign mem_adr_h       = madr_reg;
  assign mem_zero_fill_h = mzf_reg;
  assign ccl_done_intr_h = done_reg;
  assign ccl_mem_err_h   = merr_reg;
  assign ccl_ovn_err_h   = ovn_reg;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_status
    assign ccl_ccwf_req_h[gi] = (state_reg[gi] == ST_FETCH);
    assign ccl_act_h[gi]      = (state_reg[gi] == ST_ACTIVE) || (state_reg[gi] == ST_WAIT);
  end

  always_comb begin
    stat_wc_h  = '0;
    stat_adr_h = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (stat_chan_h == CHW'(i)) begin
        stat_wc_h  = wc_reg[i];
        stat_adr_h = adr_reg[i];
      end
    end
  end

endmodule

// File: doc/ccl_multi_seq.md
Name: ccl_multi_seq

Overview:
Parametrised channel command-list sequencer, the successor to the single-channel DMA20 CCL logic. It holds NCHAN independent CCW contexts (word count, address, direction, zero-fill, last flag), arbitrates them round-robin onto one memory-cycle port, and advances address and word count on each completed transfer. It requests the next CCW fetch at word-count exhaustion and raises per-channel done and error interrupts. It sits between the CCW fetch logic (crc/ccw side) and the memory/cache channel-cycle interface.

Parameters:
NCHAN, 8, number of channel contexts (2..16); CHW = max(1, clog2(NCHAN))
WCW, 11, word-count width
ADRW, 22, memory word-address width

Ports:
clk_ccl_h  in  1  clock, all state on rising edge
crc_reset_l  in  1  asynchronous active-low reset
ccw_load_h  in  1  load CCW fields into channel ccw_chan_h
ccw_chan_h  in  CHW  target channel for load
ccw_wc_h  in  WCW  word count
ccw_adr_h  in  ADRW  start address
ccw_reverse_h  in  1  1 = address decrements
ccw_zero_fill_h  in  1  transfer is zero-fill, no data
ccw_last_h  in  1  final CCW of list
ch_abort_h  in  NCHAN  per-channel abort
ch_intr_clr_h  in  NCHAN  clear done/error flags
mem_req_h  out  1  memory cycle request
mem_chan_h  out  CHW  requesting channel
mem_adr_h  out  ADRW  cycle address
mem_zero_fill_h  out  1  cycle is zero-fill
mem_ack_h  in  1  request accepted this cycle
mem_done_h  in  1  outstanding cycle complete
mem_err_h  in  1  completion carried NXM/parity error, valid with mem_done_h
ccl_ccwf_req_h  out  NCHAN  channel needs next CCW
ccl_act_h  out  NCHAN  channel ACTIVE or WAIT
ccl_done_intr_h  out  NCHAN  sticky list-complete
ccl_mem_err_h  out  NCHAN  sticky memory error
ccl_ovn_err_h  out  NCHAN  sticky load-overrun
stat_chan_h  in  CHW  diagnostic readback select
stat_wc_h  out  WCW  combinational wc of stat_chan_h
stat_adr_h  out  ADRW  combinational address of stat_chan_h

Behaviour:
- Reset: all channels IDLE; wc, adr, flags 0; all outputs 0; RR pointer = NCHAN-1 (channel 0 first).
- Per-channel states: IDLE, ACTIVE, WAIT, FETCH, DONE, ERROR.
- Load accepted in IDLE, FETCH, DONE. Fields register next edge. DONE->load clears done_intr. Next state: ACTIVE if wc!=0; if wc==0 then DONE (last=1, done_intr set) or FETCH (last=0).
- Load in ACTIVE, WAIT, ERROR: ignored; ccl_ovn_err_h set; state unchanged.
- Arbiter: evaluated when no request pending and no cycle outstanding. Picks the first ACTIVE channel after the RR pointer, wrapping. Next edge: mem_req_h=1 with chan, adr and zero_fill registered; channel ->WAIT; pointer = winner. Outputs stay stable until mem_ack_h; mem_req_h drops the edge after ack.
- One cycle outstanding globally. mem_done_h is legal no earlier than the cycle after ack; mem_done_h with nothing outstanding is ignored.
- On mem_done_h without error: wc -= 1; adr +1 (or -1 if reverse), mod 2^ADRW wrap. If new wc==0: DONE+done_intr (last) or FETCH (not last); otherwise ACTIVE. The arbiter may issue the next request the cycle after done.
- On mem_done_h with mem_err_h: channel ->ERROR; ccl_mem_err_h set; wc and adr unchanged.
- ccl_ccwf_req_h[i] = (state==FETCH), level, held until load.
- Abort: in ACTIVE, FETCH, DONE -> IDLE next edge; flags kept. In WAIT: abort-pending latched; on mem_done the channel goes IDLE, result discarded, error ignored. Pending request not yet acked completes handshake normally.
- ch_intr_clr_h: clears done_intr, mem_err, ovn_err; DONE/ERROR -> IDLE.
- Same-cycle priority, same channel: abort > load; flag set > clear; load after done/clear in same cycle: load wins, flags cleared.

Test Plan:
- Load ch2 wc=3 adr=0o100 fwd last; ack/done immediately -> adrs 0o100,0o101,0o102 on mem_adr_h; wc 3->0; done_intr[2]=1; act[2]=0.
- Load ch0,ch1,ch3 wc=2 each together via successive loads -> grants in order 0,1,3,0,1,3; each done_intr set after 6th completion overall.
- Reverse ch5 adr=0 wc=2 last=0 -> adrs 0, 2^ADRW-1; then ccwf_req[5]=1 until reload with wc=0 last=1 -> DONE same path, done_intr[5]=1.
- Ch4 first done with mem_err_h=1 -> ERROR, mem_err[4]=1, wc unchanged; load to ch4 -> ovn_err[4]=1; intr_clr[4] -> IDLE, flags 0.
- Abort ch1 in WAIT, then done with err -> ch1 IDLE, no mem_err; abort+load same cycle on IDLE ch6 -> stays IDLE.
- Assert crc_reset_l low mid-request -> mem_req_h 0 asynchronously; all flags 0; first post-reset grant goes to lowest ACTIVE channel.
